// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding a UART TX FIFO.
// Each requester streams bytes (valid/ready, last marks packet end). The owner
// keeps the grant for the whole packet. Bytes go out at most one per two
// cycles, so tx_full has time to update between writes. A stalled owner is
// dropped after TIMEOUT_CYCLES idle cycles.
// Optional feature: define UART_ARB_CHECKSUM_EN to append an XOR checksum
// byte after every completed packet.
module uart_tx_arbiter #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][7:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [7:0]            w_data,
    output logic [N_REQ-1:0]      grant,
    output logic                  timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
`ifdef UART_ARB_CHECKSUM_EN
        S_GAP,
        S_CSUM
`else
        S_GAP
`endif
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]    r_gidx, w_gidx_nxt;
    logic [PW-1:0]    r_rr, w_rr_nxt, w_rr_inc;
    logic [PW-1:0]    w_pick;
    logic             w_found;
    int               w_best, w_dist;
    logic             r_wr, w_wr_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_last, w_last_nxt;
    logic [CW-1:0]    r_stall, w_stall_nxt;
    logic             w_timeout, w_pkt_end;
    logic             w_own_valid, w_own_last;
    logic [7:0]       w_own_data;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]       r_csum, w_csum_nxt;
    logic             r_csum_done, w_csum_done_nxt;
`endif

    // Owner's request signals, selected by the one-hot grant (OR-mux).
    always_comb begin
        w_own_valid = |(req_valid & r_grant);
        w_own_last  = |(req_last & r_grant);
        w_own_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) w_own_data = w_own_data | req_data[i];
        end
    end

    // Round-robin pick: valid requester with the smallest distance from rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = N_REQ;
        w_dist  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = i - int'(r_rr);
            if (w_dist < 0) w_dist = w_dist + N_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_pick  = PW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_rr_inc = (int'(r_gidx) == N_REQ - 1) ? '0 : r_gidx + PW'(1);

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr;
        w_wr_nxt    = 1'b0;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_stall_nxt = r_stall;
        w_timeout   = 1'b0;
        w_pkt_end   = 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
        w_csum_nxt      = r_csum;
        w_csum_done_nxt = r_csum_done;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                    w_gidx_nxt  = w_pick;
                    w_last_nxt  = 1'b0;
                    w_stall_nxt = '0;
                    w_state_nxt = S_SEND;
`ifdef UART_ARB_CHECKSUM_EN
                    w_csum_nxt      = '0;
                    w_csum_done_nxt = 1'b0;
`endif
                end
            end
            S_SEND: begin
                // tx_full cycles neither accept nor count towards the stall limit
                if (!tx_full) begin
                    if (w_own_valid) begin
                        w_wr_nxt    = 1'b1;
                        w_data_nxt  = w_own_data;
                        w_last_nxt  = w_own_last;
                        w_stall_nxt = '0;
                        w_state_nxt = S_GAP;
`ifdef UART_ARB_CHECKSUM_EN
                        w_csum_nxt  = r_csum ^ w_own_data;
`endif
                    end else if (r_stall == CW'(TIMEOUT_CYCLES - 1)) begin
                        w_timeout = 1'b1;
                        w_pkt_end = 1'b1;
                    end else begin
                        w_stall_nxt = r_stall + CW'(1);
                    end
                end
            end
            S_GAP: begin
                if (r_last) begin
`ifdef UART_ARB_CHECKSUM_EN
                    if (!r_csum_done) w_state_nxt = S_CSUM;
                    else              w_pkt_end   = 1'b1;
`else
                    w_pkt_end = 1'b1;
`endif
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
`ifdef UART_ARB_CHECKSUM_EN
            S_CSUM: begin
                if (!tx_full) begin
                    w_wr_nxt        = 1'b1;
                    w_data_nxt      = r_csum;
                    w_csum_done_nxt = 1'b1;
                    w_state_nxt     = S_GAP;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        // packet end (normal or timeout): release owner, advance pointer
        if (w_pkt_end) begin
            w_grant_nxt = '0;
            w_rr_nxt    = w_rr_inc;
            w_stall_nxt = '0;
            w_state_nxt = S_IDLE;
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_rr    <= '0;
            r_wr    <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
            r_stall <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            r_csum      <= 8'h00;
            r_csum_done <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_rr    <= w_rr_nxt;
            r_wr    <= w_wr_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_stall <= w_stall_nxt;
`ifdef UART_ARB_CHECKSUM_EN
            r_csum      <= w_csum_nxt;
            r_csum_done <= w_csum_done_nxt;
`endif
        end
    end

    assign req_ready = ((r_state == S_SEND) && !tx_full) ? r_grant : '0;
    assign grant     = r_grant;
    assign wr_uart   = r_wr;
    assign w_data    = r_data;
    assign timeout   = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: drivers push expected writes when a
// byte is accepted, an independent monitor pops them on wr_uart and checks
// arbitration order, grant stability and the stall/timeout rule.
module tb_uart_tx_arbiter;
    localparam int NR = 3;
    localparam int TO = 1000;
`ifdef UART_ARB_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid, req_last, req_ready, grant;
    logic [NR-1:0][7:0] req_data;
    logic               tx_full, wr_uart, timeout;
    logic [7:0]         w_data;

    uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    logic [8:0]    txq [NR][$];     // {last, byte} per requester
    logic [7:0]    sb [$];          // expected FIFO writes
    int            owner_log [$];
    logic [NR-1:0] en = '0;
    bit            rand_bub = 0, rand_full = 0, full_force = 0, chk_space = 0;
    int            n_chk = 0, n_pass = 0, n_hs = 0, n_wr = 0, n_to = 0;
    int            cyc = 0, last_wr_cyc = -1, rr_m = 0, stall_m = 0;
    logic [NR-1:0] prev_grant = '0, prev_valid = '0;
    logic [7:0]    csum_m [NR];
    bit            acc [NR];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (txq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_pkt(input int r, input int len, input bit with_last);
        for (int b = 0; b < len; b++)
            txq[r].push_back({with_last && (b == len - 1), 8'($urandom)});
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (k < budget && !(all_empty() && sb.size() == 0 && grant == '0)) begin
            @(negedge clk); k++;
        end
        check({nm, "_drained"}, 32'(k < budget), 1);
    endtask

    task automatic wait_hs(input int target, input int budget, input string nm);
        int k = 0;
        while (k < budget && n_hs < target) begin @(negedge clk); k++; end
        check({nm, "_handshakes"}, 32'(n_hs >= target), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        for (int i = 0; i < NR; i++) txq[i].delete();
        en = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Driver: present queue heads, record accepted bytes as expected writes.
    initial begin
        int g;
        req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
        for (int i = 0; i < NR; i++) begin csum_m[i] = 8'h00; acc[i] = 1'b0; end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    if (txq[i].size() > 0) void'(txq[i].pop_front());
                    acc[i] = 1'b0;
                end
            end
            tx_full = rand_full ? ($urandom_range(0, 4) == 0) : full_force;
            for (int i = 0; i < NR; i++) begin
                if (en[i] && txq[i].size() > 0 && !(rand_bub && $urandom_range(0, 3) == 0)) begin
                    req_valid[i] = 1'b1;
                    req_data[i]  = txq[i][0][7:0];
                    req_last[i]  = txq[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NR; i++) begin acc[i] = 1'b0; csum_m[i] = 8'h00; end
            end else begin
                if (timeout) begin
                    g = oh2i(grant);
                    if (g >= 0) csum_m[g] = 8'h00;
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        acc[i] = 1'b1;
                        n_hs++;
                        sb.push_back(req_data[i]);
                        csum_m[i] = csum_m[i] ^ req_data[i];
                        if (req_last[i]) begin
                            if (CS != 0) sb.push_back(csum_m[i]);
                            csum_m[i] = 8'h00;
                        end
                    end
                end
            end
        end
    end

    // Monitor: writes vs scoreboard, round-robin order, stall/timeout model.
    initial begin
        int g, j;
        bit stall, exp_to;
        logic [NR-1:0] exp_oh;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_uart) n_wr++;
            if (rst) begin
                sb.delete();
                rr_m = 0; stall_m = 0; prev_grant = '0; last_wr_cyc = -1;
                prev_valid = req_valid;
            end else begin
                if (wr_uart) begin
                    if (sb.size() == 0) check("wr_pending", sb.size(), 1);
                    else check("wr_data", w_data, sb.pop_front());
                    if (chk_space && last_wr_cyc >= 0) check("wr_spacing", cyc - last_wr_cyc, 2);
                    last_wr_cyc = cyc;
                end
                if (prev_grant == '0 && grant != '0) begin
                    exp_oh = '0;
                    for (int k = 0; k < NR; k++) begin
                        j = (rr_m + k) % NR;
                        if (exp_oh == '0 && prev_valid[j]) exp_oh[j] = 1'b1;
                    end
                    check("rr_grant", grant, exp_oh);
                    owner_log.push_back(oh2i(grant));
                    stall_m = 0;
                end else if (prev_grant != '0 && grant == '0) begin
                    rr_m = (oh2i(prev_grant) + 1) % NR;
                end else if (prev_grant != '0 && grant != prev_grant) begin
                    check("grant_hold", grant, prev_grant);
                end
                stall = 1'b0;
                g = oh2i(grant);
                if (g >= 0) begin
                    if (req_valid[g] && req_ready[g]) stall_m = 0;
                    else if (!tx_full && !req_valid[g] && !wr_uart) begin
                        stall = 1'b1; stall_m++;
                    end
                end
                exp_to = stall && (stall_m == TO);
                if (timeout || exp_to) check("timeout_cycle", timeout, exp_to);
                if (timeout) begin n_to++; stall_m = 0; end
                prev_grant = grant;
                prev_valid = req_valid;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        logic [7:0] msg [8];
        int w0, h0, t0, nf, k;
        msg = '{8'h50, 8'h3A, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        for (int b = 0; b < 8; b++) txq[0].push_back({b == 7, msg[b]});
        en = '1;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_wdata", w_data, 0);
        check("rst_timeout", timeout, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);

        // single packet at full rate
        chk_space = 1; w0 = n_wr; owner_log.delete();
        wait_idle(400, "t029");
        chk_space = 0;
        check("t029_writes", n_wr - w0, 8 + CS);
        check("t029_owner", (owner_log.size() == 1) ? owner_log[0] : -1, 0);
        repeat (3) @(negedge clk);
        check("t029_grant_idle", grant, 0);

        // two continuous requesters alternate
        do_reset(); owner_log.delete();
        for (int p = 0; p < 3; p++) begin add_pkt(0, 3, 1); add_pkt(1, 3, 1); end
        en = 3'b011;
        wait_idle(600, "t030");
        check("t030_npkts", owner_log.size(), 6);
        for (int i = 0; i < owner_log.size() && i < 6; i++)
            check($sformatf("t030_order%0d", i), owner_log[i], i % 2);

        // FIFO full for 20 cycles mid-packet
        en = 3'b001; add_pkt(0, 8, 1); h0 = n_hs;
        wait_hs(h0 + 3, 100, "t031");
        full_force = 1; nf = 0; k = 0;
        while (nf < 20 && k < 100) begin
            @(negedge clk); k++;
            if (tx_full) begin
                nf++;
                check("t031_ready", req_ready, 0);
                check("t031_timeout", timeout, 0);
                if (nf >= 2) check("t031_nowr", wr_uart, 0);
            end
        end
        full_force = 0;
        wait_idle(200, "t031");

        // owner stalls until timeout, next requester takes over
        do_reset(); owner_log.delete(); t0 = n_to;
        add_pkt(0, 2, 0); add_pkt(1, 2, 1); en = 3'b011;
        k = 0;
        while (n_to == t0 && k < 1500) begin @(negedge clk); k++; end
        check("t032_timeout_seen", n_to - t0, 1);
        wait_idle(200, "t032");
        check("t032_npkts", owner_log.size(), 2);
        check("t032_next_owner", (owner_log.size() >= 2) ? owner_log[1] : -1, 1);

`ifdef UART_ARB_CHECKSUM_EN
        // checksum appended: 41, 42, 03
        en = 3'b001; w0 = n_wr;
        txq[0].push_back({1'b0, 8'h41}); txq[0].push_back({1'b1, 8'h42});
        wait_idle(100, "t033");
        check("t033_writes", n_wr - w0, 3);
`endif

        // reset mid-packet, then requester 0 wins first
        add_pkt(1, 8, 1); en = 3'b010; h0 = n_hs;
        wait_hs(h0 + 3, 100, "t034");
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("t034_grant", grant, 0);
        check("t034_ready", req_ready, 0);
        check("t034_wr", wr_uart, 0);
        check("t034_wdata", w_data, 0);
        check("t034_timeout", timeout, 0);
        for (int i = 0; i < NR; i++) txq[i].delete();
        en = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        owner_log.delete();
        add_pkt(1, 1, 1); add_pkt(0, 1, 1); en = 3'b011;
        wait_idle(100, "t034");
        check("t034_first_owner", (owner_log.size() > 0) ? owner_log[0] : -1, 0);

        // randomized traffic with bubbles and FIFO backpressure
        rand_bub = 1; rand_full = 1; en = '1;
        for (int p = 0; p < 30; p++)
            add_pkt($urandom_range(0, NR - 1), $urandom_range(1, 5), 1);
        wait_idle(6000, "rand");
        rand_bub = 0; rand_full = 0;
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, the number of packet requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, the stall limit in cycles for a granted requester mid-packet.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, N_REQ bits: per-requester byte valid.
REQ-006 SHALL have port req_data, input, N_REQ x 8 bits: per-requester byte.
REQ-007 SHALL have port req_last, input, N_REQ bits: marks the final byte of a packet.
REQ-008 SHALL have port req_ready, output, N_REQ bits: byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port tx_full, input, 1 bit: UART TX FIFO full.
REQ-010 SHALL have port wr_uart, output, 1 bit: one-cycle FIFO write strobe.
REQ-011 SHALL have port w_data, output, 8 bits: FIFO write data.
REQ-012 SHALL have port grant, output, N_REQ bits: one-hot owner, all zero when idle.
REQ-013 SHALL have port timeout, output, 1 bit: one-cycle pulse on packet abort.

Function
REQ-014 SHALL implement states S_IDLE, S_SEND, S_GAP, S_CSUM; S_CSUM exists only with the macro in REQ-027.
REQ-015 In S_IDLE with any req_valid high, SHALL grant the first requester at or after rr_ptr in round-robin order, register grant, and enter S_SEND next cycle.
REQ-016 SHALL keep grant constant from grant to packet end; other requesters are ignored.
REQ-017 req_ready[g] SHALL be high only in S_SEND, only for the owner g, and only while tx_full=0; req_ready is combinational from state, grant and tx_full.
REQ-018 On an accepted byte, SHALL register wr_uart=1 and w_data=req_data[g] next cycle, then enter S_GAP.
REQ-019 S_GAP SHALL last exactly one cycle, to absorb tx_full update latency; it returns to S_SEND, or ends the packet if the accepted byte had req_last=1.
REQ-020 Packet end SHALL clear grant, set rr_ptr=(g+1) mod N_REQ, and enter S_IDLE; the next arbitration happens no earlier than the following cycle.
REQ-021 wr_uart SHALL be 0 in every cycle without an accepted byte or checksum write; w_data holds its last value.
REQ-022 A stall counter SHALL count S_SEND cycles with req_valid[g]=0 and reset on each accept; tx_full=1 cycles do not count.
REQ-023 When the stall counter reaches TIMEOUT_CYCLES, SHALL pulse timeout for 1 cycle, drop the packet without a checksum, and apply REQ-020.
REQ-024 Maximum throughput SHALL be one byte per 2 cycles.

Reset
REQ-025 During and after rst, the block SHALL hold state=S_IDLE, grant=0, req_ready=0, wr_uart=0, w_data=8'h00, timeout=0, rr_ptr=0, stall counter=0, checksum=0.
REQ-026 Reset mid-packet SHALL abandon the packet immediately with no further writes; no partial-packet recovery.

Configuration
REQ-027 With UART_ARB_CHECKSUM_EN defined, SHALL XOR all accepted bytes of a packet, including the last byte, then after the last S_GAP enter S_CSUM. S_CSUM waits for tx_full=0, writes the checksum (wr_uart=1), then proceeds per REQ-020 after one S_GAP cycle. The checksum clears at grant.
REQ-028 Without UART_ARB_CHECKSUM_EN, the S_CSUM state and the checksum logic SHALL be absent, and packets pass unchanged.

Verification
REQ-029 Stimulus: requester 0 sends "P:0123\r\n" with tx_full=0. Response: 8 writes, 2 cycles apart, in order, then grant=0.
REQ-030 Stimulus: requesters 0 and 1 both valid continuously after reset. Response: packets alternate 0,1,0,1 and bytes never interleave.
REQ-031 Stimulus: tx_full=1 for 20 cycles mid-packet. Response: no wr_uart, req_ready=0, no timeout, and the stream resumes intact.
REQ-032 Stimulus: the owner drops req_valid for TIMEOUT_CYCLES=1000. Response: timeout pulses on the 1000th stall cycle, grant=0, and the next requester is granted.
REQ-033 Stimulus: packet 8'h41,8'h42 (last) with UART_ARB_CHECKSUM_EN defined. Response: writes 41,42,03.
REQ-034 Stimulus: rst asserted after 3 bytes. Response: all outputs take reset values asynchronously, and after release requester 0 is granted first.
